// File: rtl/fifo_defs.sv
// Shared FIFO sizing constants for the RAM-backed byte FIFO and its storage array.
package fifo_defs;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEPTH        = 1 << DEF_ADDR_W;
   localparam int DEF_CNT_W    = DEF_ADDR_W + 1;
   localparam int DEF_AF_LEVEL = 240;
   localparam int DEF_AE_LEVEL = 16;
endpackage

// File: rtl/DualPortRAM.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on address collision.
module DualPortRAM
   import fifo_defs::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              en,
   input  logic [ADDR_W-1:0] readAddr,
   output logic [DATA_W-1:0] dataOut
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Both ports sit in one process so a same-address read sees the pre-write byte.
   always_ff @(posedge clk) begin
      if (we) mem[writeAddr] <= dataIn;
      if (en) dataOut <= mem[readAddr];
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Synchronous byte FIFO controller: pointers, occupancy, flags and enables around a 256x8 RAM.
module ram_fifo_ctrl
   import fifo_defs::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int AF_LEVEL = DEF_AF_LEVEL,
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wrEn,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEn,
   output logic [DATA_W-1:0] rdData,
   output logic              rdValid,
   output logic              full,
   output logic              empty,
   output logic              almostFull,
   output logic              almostEmpty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << ADDR_W);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic              clr, push_ok, pop_ok;

   assign clr     = reset | flush;
   assign pop_ok  = rdEn & ~empty;
   assign push_ok = wrEn & (~full | pop_ok);

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Flags come from count_nxt so they are registered yet never a cycle stale.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         empty       <= 1'b1;
         almostEmpty <= 1'b1;
         full        <= 1'b0;
         almostFull  <= 1'b0;
         rdValid     <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count       <= count_nxt;
         empty       <= (count_nxt == '0);
         almostEmpty <= (count_nxt <= AE_CNT);
         full        <= (count_nxt == FULL_CNT);
         almostFull  <= (count_nxt >= AF_CNT);
         rdValid     <= pop_ok;
         if (wrEn & ~push_ok) overflow  <= 1'b1;
         if (rdEn & ~pop_ok)  underflow <= 1'b1;
      end
   end

   // Reset/flush abort any in-flight access, so RAM strobes are masked while clearing.
   DualPortRAM #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .we        (push_ok & ~clr),
      .writeAddr (wr_ptr),
      .dataIn    (wrData),
      .en        (pop_ok & ~clr),
      .readAddr  (rd_ptr),
      .dataOut   (rdData)
   );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl: expected pop data queued at issue, checked by a monitor on rdValid.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       reset, flush, wrEn, rdEn;
   logic [7:0] wrData;
   logic [7:0] rdData;
   logic       rdValid, full, empty, almostFull, almostEmpty, overflow, underflow;
   logic [8:0] count;

   int         nvec = 0;
   int         nmis = 0;
   logic [7:0] sbq [$];

   always #5 clk = ~clk;

   ram_fifo_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .wrEn        (wrEn),
      .wrData      (wrData),
      .rdEn        (rdEn),
      .rdData      (rdData),
      .rdValid     (rdValid),
      .full        (full),
      .empty       (empty),
      .almostFull  (almostFull),
      .almostEmpty (almostEmpty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   // Monitor: every rdValid must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rdValid === 1'b1) begin
         nvec++;
         if (sbq.size() == 0) begin
            nmis++;
            $display("FAIL unexpected_rdValid got data=%02h required no rdValid", rdData);
         end else begin
            e = sbq.pop_front();
            if (rdData !== e) begin
               nmis++;
               $display("FAIL pop_data got %02h required %02h", rdData, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
      wrEn = w; wrData = d; rdEn = r; flush = f;
      @(posedge clk); #1;
      wrEn = 1'b0; rdEn = 1'b0; flush = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic [7:0] e);
      sbq.push_back(e);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; wrEn = 1'b0; rdEn = 1'b0; wrData = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_empty", int'(empty), 1);
      chk("rst_almostEmpty", int'(almostEmpty), 1);
      chk("rst_count", int'(count), 0);
      chk("rst_rdValid", int'(rdValid), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_almostFull", int'(almostFull), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_underflow", int'(underflow), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_empty", int'(empty), 1);

      push(8'h11); push(8'h22); push(8'h33);
      chk("three_count", int'(count), 3);
      chk("three_empty", int'(empty), 0);
      pop(8'h11); pop(8'h22); pop(8'h33);
      chk("drain3_count", int'(count), 0);
      chk("drain3_empty", int'(empty), 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 256; i++) begin
         push(8'(i));
         chk("fill_count", int'(count), i + 1);
         chk("fill_almostFull", int'(almostFull), (i + 1 >= 240) ? 1 : 0);
         chk("fill_almostEmpty", int'(almostEmpty), (i + 1 <= 16) ? 1 : 0);
         chk("fill_full", int'(full), (i == 255) ? 1 : 0);
      end
      push(8'hEE);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_count", int'(count), 256);

      sbq.push_back(8'h00);
      cyc(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("fullpp_count", int'(count), 256);
      chk("fullpp_full", int'(full), 1);
      for (int i = 1; i < 256; i++) pop(8'(i));
      pop(8'hAA);
      chk("drain_count", int'(count), 0);
      chk("drain_empty", int'(empty), 1);
      chk("drain_ovf_sticky", int'(overflow), 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      cyc(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("emptypp_count", int'(count), 1);
      chk("emptypp_underflow", int'(underflow), 1);
      chk("emptypp_rdValid", int'(rdValid), 0);
      pop(8'h5A);
      chk("emptypp_after_count", int'(count), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
      chk("pre_flush_count", int'(count), 10);
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      chk("flush_count", int'(count), 0);
      chk("flush_empty", int'(empty), 1);
      chk("flush_rdValid", int'(rdValid), 0);
      chk("flush_almostEmpty", int'(almostEmpty), 1);
      chk("flush_overflow", int'(overflow), 0);
      chk("flush_underflow", int'(underflow), 0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
